// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set-2 sequence decoder: turns receiver bytes into make/break key
// events, queues them in a first-word-fall-through FIFO and tracks held game keys.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_extended,
  output logic       evt_break,
  output logic       evt_overflow,
  output logic [5:0] key_held
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   COUNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ev_push, ev_ext, ev_brk;
  logic [5:0]    held_q, held_d;

  // ---------------------------------------------------------------- sequence FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    ev_push = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    // A strobe always takes priority over an expiring timeout.
    if (received_data_en) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          unique case (received_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: ev_push = 1'b1;
          endcase
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (received_data != 8'hE0) begin
            ev_push = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          if (received_data != 8'hF0) begin
            ev_push = 1'b1;
            ev_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT_BRK: begin
          if (received_data != 8'hF0) begin
            ev_push = 1'b1;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // ---------------------------------------------------------------- held keys
  always_comb begin
    held_d = held_q;
    if (ev_push) begin
      unique case ({ev_ext, received_data})
        9'h175:  held_d[0] = ~ev_brk;
        9'h172:  held_d[1] = ~ev_brk;
        9'h16B:  held_d[2] = ~ev_brk;
        9'h174:  held_d[3] = ~ev_brk;
        9'h029:  held_d[4] = ~ev_brk;
        9'h05A:  held_d[5] = ~ev_brk;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) held_q <= '0;
    else       held_q <= held_d;
  end

  assign key_held = held_q;

  // ---------------------------------------------------------------- event FIFO
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [9:0]    hold_q, head;
  logic          overflow_q;
  logic          pop, full, push_ok, drop;

  assign head    = mem[rd_ptr];
  assign pop     = (count != '0) && evt_ready;
  assign full    = (count == COUNT_FULL);
  assign push_ok = ev_push && (!full || pop);
  assign drop    = ev_push && full && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {ev_ext, ev_brk, received_data};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        hold_q <= head;
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Once drained, the outputs keep showing the last popped event.
  assign evt_valid = (count != '0);
  assign {evt_extended, evt_break, evt_code} = evt_valid ? head : hold_q;
  assign evt_overflow = overflow_q;

endmodule
